// File: rtl/apb_req_bridge.sv
// apb_req_bridge: single-outstanding bridge from a core-side req/gnt/rvalid
// data port to an APB3 master. Requests outside [WIN_START, WIN_END] are
// answered locally with an error and never reach the APB bus.
//
// Optional feature: define APB_TIMEOUT_EN to bound the ACCESS phase to
// TIMEOUT_CYCLES cycles. A timed-out transfer completes with err=1, rdata=0.
//
// Handshake: a request is accepted in any cycle where req_i && gnt_o. gnt_o
// can only be high in IDLE, so at most one request is outstanding. Each
// accepted request gets exactly one response, signalled by a single-cycle
// rvalid_o pulse. rdata_o/err_o are meaningful only while rvalid_o is high and
// read as 0 otherwise. An asynchronous reset drops any transfer in flight, and
// that request gets no response.
module apb_req_bridge #(
    parameter int          APB_ADDR_WIDTH = 32,
    parameter int          APB_DATA_WIDTH = 32,
    parameter logic [31:0] WIN_START      = 32'h1A10_0000,
    parameter logic [31:0] WIN_END        = 32'h1A11_7FFF,
    parameter int          TIMEOUT_CYCLES = 256
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic                      req_i,
    output logic                      gnt_o,
    input  logic [31:0]               addr_i,
    input  logic                      we_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic [APB_ADDR_WIDTH-1:0] PADDR,
    output logic [APB_DATA_WIDTH-1:0] PWDATA,
    output logic                      PWRITE,
    output logic                      PSEL,
    output logic                      PENABLE,
    input  logic [APB_DATA_WIDTH-1:0] PRDATA,
    input  logic                      PREADY,
    input  logic                      PSLVERR,
    output logic [1:0]                dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                      in_win;
    logic                      tmo_hit;
    logic [APB_DATA_WIDTH-1:0] rdata_q;
    logic                      err_q;

    // Full 32-bit unsigned window compare, both bounds inclusive.
    assign in_win = (addr_i >= WIN_START) && (addr_i <= WIN_END);

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] tmo_cnt;

    // Count ACCESS cycles that are still waiting; cleared while in SETUP so it starts at 0 on ACCESS entry.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            tmo_cnt <= '0;
        end else if (state_q == SETUP) begin
            tmo_cnt <= '0;
        end else if (state_q == ACCESS && !PREADY) begin
            tmo_cnt <= tmo_cnt + CW'(1);
        end
    end

    // Timeout fires on the last allowed wait cycle; PREADY in that cycle still completes normally.
    always_comb begin
        tmo_hit = (state_q == ACCESS) && !PREADY && (tmo_cnt == CW'(TIMEOUT_CYCLES - 1));
    end
`else
    logic unused_timeout;

    // No timeout: ACCESS waits for PREADY indefinitely.
    always_comb begin
        tmo_hit        = 1'b0;
        unused_timeout = (TIMEOUT_CYCLES == 0);
    end
`endif

    // State register; reset aborts any transfer in flight.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_i) begin
                    state_d = in_win ? SETUP : RESP;
                end
            end
            SETUP:  state_d = ACCESS;
            ACCESS: begin
                if (PREADY || tmo_hit) begin
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from the registered state.
    always_comb begin
        gnt_o     = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rvalid_o  = 1'b0;
        dbg_state = state_q;
        case (state_q)
            IDLE:    gnt_o = req_i;
            SETUP:   PSEL = 1'b1;
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
            end
            RESP:    rvalid_o = 1'b1;
            default: ;
        endcase
    end

    // Response data is gated so it reads as 0 outside the rvalid pulse.
    always_comb begin
        rdata_o = rvalid_o ? rdata_q : '0;
        err_o   = rvalid_o & err_q;
    end

    // APB address/data/direction: loaded only when an in-window request is granted, held otherwise.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            PADDR  <= '0;
            PWDATA <= '0;
            PWRITE <= 1'b0;
        end else if (state_q == IDLE && req_i && in_win) begin
            PADDR  <= addr_i[APB_ADDR_WIDTH-1:0];
            PWDATA <= wdata_i;
            PWRITE <= we_i;
        end
    end

    // Response capture: local reject, APB completion or timeout; cleared after the response cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && !in_win) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                ACCESS: begin
                    if (PREADY) begin
                        rdata_q <= PWRITE ? '0 : PRDATA;
                        err_q   <= PSLVERR;
                    end else if (tmo_hit) begin
                        rdata_q <= '0;
                        err_q   <= 1'b1;
                    end
                end
                RESP: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
